// File: rtl/pll_serdes_pkg.sv
// Shared types and helpers for the divided-clock lock detector.
package pll_serdes_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } lock_state_t;

  // True when |meas - exp_val| <= tol. The extra sign bit keeps the
  // difference from wrapping when meas is smaller than exp_val.
  function automatic logic in_tol(input logic [31:0] meas,
                                  input logic [31:0] exp_val,
                                  input logic [31:0] tol);
    logic signed [32:0] diff;
    diff = $signed({1'b0, meas}) - $signed({1'b0, exp_val});
    if (diff < 0) diff = -diff;
    return (diff <= $signed({1'b0, tol}));
  endfunction

endpackage

// File: rtl/div_clk_sync.sv
// Brings the asynchronous divided clock into the clk domain and flags
// every transition (either polarity) as a one-cycle edge.
module div_clk_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic edge_det
);

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   s;
  logic                   s_d;

  assign s        = sync_p[SYNC_STAGES-1];
  assign edge_det = s ^ s_d;

  // Synchroniser chain plus one-cycle delayed copy for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p <= '0;
      s_d    <= 1'b0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], async_in};
      s_d    <= s;
    end
  end

endmodule

// File: rtl/div_clk_lock_detector.sv
// Measures each half-period of the divided clock in clk cycles, tracks
// consecutive good measurements and reports lock / loss of lock.
module div_clk_lock_detector
  import pll_serdes_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int HALF_PERIOD = 5,
  parameter int TOL         = 0,
  parameter int LOCK_COUNT  = 4,
  parameter int TIMEOUT     = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             enable,
  output logic             locked,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             err,
  output logic             lost
);

  localparam int GC_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TO_THR  = CNT_W'(TIMEOUT - 1);

  lock_state_t     state, state_nxt;
  logic [CNT_W-1:0] run_cnt;
  logic [GC_W-1:0]  good_cnt, good_cnt_nxt;
  logic             first_edge, first_edge_nxt;
  logic             locked_nxt, err_nxt, lost_nxt;
  logic             edge_det;
  logic             active, meas_evt, disc_evt, timeout, good, bad_evt;

  div_clk_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (div_in),
    .edge_det (edge_det)
  );

  assign active   = enable && (state != IDLE);
  assign meas_evt = active && edge_det && !first_edge;
  assign disc_evt = active && edge_det && first_edge;
  // An edge in the threshold cycle is a measurement, never a timeout.
  assign timeout  = active && !edge_det && (run_cnt == TO_THR);
  assign good     = in_tol(32'(run_cnt), 32'(HALF_PERIOD), 32'(TOL));
  assign bad_evt  = (meas_evt && !good) || timeout;

  // Next-state and pulse decode for the lock FSM
  always_comb begin
    state_nxt      = state;
    good_cnt_nxt   = good_cnt;
    first_edge_nxt = first_edge;
    locked_nxt     = locked;
    err_nxt        = 1'b0;
    lost_nxt       = 1'b0;
    if (disc_evt) first_edge_nxt = 1'b0;
    if (timeout)  first_edge_nxt = 1'b1;
    if (!enable) begin
      state_nxt      = IDLE;
      locked_nxt     = 1'b0;
      good_cnt_nxt   = '0;
      first_edge_nxt = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          state_nxt      = ACQUIRE;
          good_cnt_nxt   = '0;
          first_edge_nxt = 1'b1;
        end
        ACQUIRE: begin
          if (bad_evt) begin
            good_cnt_nxt = '0;
            err_nxt      = 1'b1;
          end else if (meas_evt) begin
            if (32'(good_cnt) + 32'd1 == 32'(LOCK_COUNT)) begin
              state_nxt    = LOCKED;
              locked_nxt   = 1'b1;
              good_cnt_nxt = '0;
            end else begin
              good_cnt_nxt = good_cnt + 1'b1;
            end
          end
        end
        LOCKED: begin
          if (bad_evt) begin
            state_nxt    = ACQUIRE;
            locked_nxt   = 1'b0;
            lost_nxt     = 1'b1;
            good_cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // State, run counter, measurement and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      run_cnt     <= '0;
      good_cnt    <= '0;
      first_edge  <= 1'b1;
      locked      <= 1'b0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      err         <= 1'b0;
      lost        <= 1'b0;
    end else begin
      state      <= state_nxt;
      good_cnt   <= good_cnt_nxt;
      first_edge <= first_edge_nxt;
      locked     <= locked_nxt;
      err        <= err_nxt;
      lost       <= lost_nxt;
      meas_valid <= meas_evt;
      if (meas_evt) half_period <= run_cnt;
      if (edge_det)               run_cnt <= CNT_W'(1);
      else if (run_cnt != CNT_MAX) run_cnt <= run_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_div_clk_lock_detector.sv
// Scoreboard bench for div_clk_lock_detector: directed half-period
// sequences push hand-computed events; a monitor pops them on every
// meas_valid / err / lost pulse.
module tb_div_clk_lock_detector;

  logic       clk = 1'b0;
  logic       rst;
  logic       div_in;
  logic       enable;
  logic       locked;
  logic [7:0] half_period;
  logic       meas_valid;
  logic       err;
  logic       lost;

  typedef struct {
    logic       mv;
    logic [7:0] hp;
    logic       er;
    logic       ls;
    logic       lk;
  } ev_t;

  ev_t q[$];
  ev_t e;
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  div_clk_lock_detector #(
    .CNT_W(8), .HALF_PERIOD(5), .TOL(1), .LOCK_COUNT(4),
    .TIMEOUT(16), .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .enable      (enable),
    .locked      (locked),
    .half_period (half_period),
    .meas_valid  (meas_valid),
    .err         (err),
    .lost        (lost)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic ev(input logic mv, input int hp, input logic er, input logic ls, input logic lk);
    ev_t x;
    x.mv = mv; x.hp = 8'(hp); x.er = er; x.ls = ls; x.lk = lk;
    q.push_back(x);
  endtask

  // Toggle div_in now (posedge+1) and hold the new level for 'hold' clk cycles.
  task automatic t(input int hold);
    div_in = ~div_in;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (meas_valid || err || lost) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event mv=%0d err=%0d lost=%0d hp=%0d required=none",
                 meas_valid, err, lost, half_period);
      end else begin
        e = q.pop_front();
        chk("ev_meas_valid", 32'(meas_valid), 32'(e.mv));
        if (e.mv) chk("ev_half_period", 32'(half_period), 32'(e.hp));
        chk("ev_err", 32'(err), 32'(e.er));
        chk("ev_lost", 32'(lost), 32'(e.ls));
        chk("ev_locked", 32'(locked), 32'(e.lk));
      end
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; div_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_locked", 32'(locked), 0);
    chk("rst_half_period", 32'(half_period), 0);
    chk("rst_meas_valid", 32'(meas_valid), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_lost", 32'(lost), 0);
    rst = 1'b0; enable = 1'b1;

    // Nominal period 5: first edge discarded, lock after 4th good
    t(5);
    repeat (3) begin ev(1, 5, 0, 0, 0); t(5); end
    ev(1, 5, 0, 0, 1); t(5);
    ev(1, 5, 0, 0, 1); t(7);
    // One half-period of 7 while locked: lost, then relock
    ev(1, 7, 0, 1, 0); t(5);
    repeat (3) begin ev(1, 5, 0, 0, 0); t(5); end
    // Stuck clock while locked: single lost from the timeout
    ev(1, 5, 0, 0, 1);
    ev(0, 0, 0, 1, 0); t(30);
    t(5);
    ev(1, 5, 0, 0, 0); t(8);
    // Bad measurement in ACQUIRE gives err; then tolerance edges 4,6,5,4
    ev(1, 8, 1, 0, 0); t(4);
    ev(1, 4, 0, 0, 0); t(6);
    ev(1, 6, 0, 0, 0); t(5);
    ev(1, 5, 0, 0, 0); t(4);
    ev(1, 4, 0, 0, 1); t(3);
    ev(1, 3, 0, 1, 0); t(5);
    repeat (3) begin ev(1, 5, 0, 0, 0); t(5); end
    ev(1, 5, 0, 0, 1);
    div_in = ~div_in;
    repeat (5) @(posedge clk);
    #1;
    // Drop enable while locked: locked clears, no lost, half_period held
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("dis_locked", 32'(locked), 0);
    chk("dis_half_period", 32'(half_period), 5);
    repeat (20) @(posedge clk);
    #1;
    enable = 1'b1;
    t(5);
    ev(1, 5, 0, 0, 0);
    div_in = ~div_in;
    repeat (4) @(posedge clk);
    #1;
    // Reset mid-half-period
    rst = 1'b1; div_in = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_locked", 32'(locked), 0);
    chk("mid_rst_half_period", 32'(half_period), 0);
    chk("mid_rst_meas_valid", 32'(meas_valid), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_lost", 32'(lost), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    t(5);
    repeat (3) begin ev(1, 5, 0, 0, 0); t(5); end
    ev(1, 5, 0, 0, 1); t(15);
    // Edge in the threshold cycle is a measurement (15, bad -> lost)
    ev(1, 15, 0, 1, 0);
    // A 16-cycle level times out in ACQUIRE; the late edge is discarded
    ev(0, 0, 1, 0, 0); t(16);
    t(5);
    ev(1, 5, 0, 0, 0); t(5);
    repeat (10) @(posedge clk);
    #1;
    chk("pending_events", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
